// File: rtl/data_mem_bus_ctrl.sv
// Data-memory bus controller. It sits between the load/store unit and a valid/ready data bus.
// The controller moves lane-0 aligned store data and strobes onto the byte lanes for the access.
// It runs one request/response transaction at a time and stalls the core until that transaction
// finishes. Load data comes back right-justified to lane 0. Misaligned accesses are rejected
// without any bus activity, and a transaction that never completes is aborted as a bus error.
module data_mem_bus_ctrl #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [1:0]      size_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] write_data_i,
  input  logic [3:0]      write_strobe_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] read_data_o,
  output logic            misaligned_o,
  output logic            bus_err_o,
  output logic            bus_valid_o,
  input  logic            bus_ready_i,
  output logic [XLEN-1:0] bus_addr_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_wdata_o,
  output logic [3:0]      bus_wstrb_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  input  logic            bus_err_i
);

  // The counter only has to reach TIMEOUT_CYCLES-1 before the FSM leaves ADDR/RESP.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misal_q, misal_d;
  logic              err_q, err_d;

  logic              misaligned;
  logic              timeout;

  // Half accesses need an even offset; word accesses (size 2 or 3) need offset 0.
  assign misaligned = ((size_i == 2'd1) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
  assign timeout    = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Next-state logic: FSM transitions, request capture, timeout counting and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    misal_d = misal_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req_i) begin
          if (misaligned) begin
            state_d = StDone;
            misal_d = 1'b1;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            state_d = StAddr;
            cnt_d   = '0;
            off_d   = addr_i[1:0];
            addr_d  = {addr_i[XLEN-1:2], 2'b00};
            we_d    = mem_we_i;
            wdata_d = write_data_i << {addr_i[1:0], 3'b000};
            wstrb_d = mem_we_i ? (write_strobe_i << addr_i[1:0]) : 4'b0000;
          end
        end
      end
      StAddr: begin
        cnt_d = cnt_q + CntW'(1);
        // A bus_ready_i is not a completion, so timeout takes priority here.
        if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (bus_ready_i) begin
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d = cnt_q + CntW'(1);
        // A response in the last allowed cycle still counts as completion.
        if (bus_rvalid_i) begin
          state_d = StDone;
          rdata_d = bus_rdata_i >> {off_q, 3'b000};
          err_d   = bus_err_i;
        end else if (timeout) begin
          state_d = StDone;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        rdata_d = '0;
        misal_d = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset is asynchronous, so any transaction is aborted at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      rdata_q <= '0;
      misal_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
      err_q   <= err_d;
    end
  end

  // Output decode. In IDLE the stall follows the request combinationally; during reset it is 0.
  always_comb begin
    stall_o      = 1'b0;
    unique case (state_q)
      StIdle:         stall_o = mem_req_i & rst_ni;
      StAddr, StResp: stall_o = 1'b1;
      default:        stall_o = 1'b0;
    endcase
    done_o       = (state_q == StDone);
    bus_valid_o  = (state_q == StAddr);
    read_data_o  = rdata_q;
    misaligned_o = misal_q;
    bus_err_o    = err_q;
    bus_addr_o   = addr_q;
    bus_we_o     = we_q;
    bus_wdata_o  = wdata_q;
    bus_wstrb_o  = wstrb_q;
  end

endmodule

// File: doc/data_mem_bus_ctrl.md
Name: data_mem_bus_ctrl

Overview:
- Sits directly downstream of the load/store unit, between the core datapath and the data-memory bus.
- Takes byte-lane-0-aligned store data and strobes plus the effective address, and shifts them onto the correct byte lanes.
- Runs a valid/ready request and response transaction on the bus and stalls the core until the transaction completes.
- Returns read data right-justified to lane 0, so the load/store unit can sign- or zero-extend it. Also detects misaligned accesses and bus timeouts.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum number of cycles spent in ADDR plus RESP before the transaction is aborted.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_req_i  in  1  core requests a data access; held stable while stall_o=1.
- mem_we_i  in  1  1=store, 0=load.
- size_i  in  2  access size: 0=byte, 1=half, 2=word; 3 is treated as word.
- addr_i  in  XLEN  byte address.
- write_data_i  in  XLEN  store data, lane-0 aligned.
- write_strobe_i  in  4  store strobes, lane-0 aligned.
- stall_o  out  1  core must hold its inputs.
- done_o  out  1  one-cycle completion pulse.
- read_data_o  out  XLEN  load data, lane-0 aligned; valid while done_o=1.
- misaligned_o  out  1  access was rejected as misaligned; valid while done_o=1.
- bus_err_o  out  1  bus error or timeout; valid while done_o=1.
- bus_valid_o  out  1  bus request valid.
- bus_ready_i  in  1  bus accepts the request.
- bus_addr_o  out  XLEN  word address, {addr_i[31:2],2'b00}.
- bus_we_o  out  1  bus write enable.
- bus_wdata_o  out  XLEN  write data shifted onto byte lanes.
- bus_wstrb_o  out  4  byte-lane strobes.
- bus_rvalid_i  in  1  response valid; also acts as the write acknowledge.
- bus_rdata_i  in  XLEN  response data.
- bus_err_i  in  1  response error, sampled together with bus_rvalid_i.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including bus_valid_o, which drops immediately.
  - No pending response is remembered after reset.
- Address handling:
  - off=addr_i[1:0].
  - Misaligned when size=half and off[0]=1, or size=word and off!=0.
- Lane shifting (registered on the IDLE->ADDR transition and held constant through ADDR):
  - bus_wdata_o = write_data_i << (8*off).
  - bus_wstrb_o = write_strobe_i << off, truncated to 4 bits.
  - Loads drive bus_wstrb_o=0000.
- Read return: read_data_o = bus_rdata_i >> (8*off), zero-filled, captured when bus_rvalid_i=1 in RESP.
- FSM states: IDLE, ADDR, RESP, DONE.
  - IDLE:
    - stall_o = mem_req_i.
    - mem_req_i=1 and aligned -> ADDR.
    - mem_req_i=1 and misaligned -> DONE with misaligned_o=1 and no bus activity.
  - ADDR:
    - bus_valid_o=1 and stall_o=1.
    - bus_ready_i=1 -> RESP.
    - Address, data and strobes remain stable until accepted.
  - RESP:
    - bus_valid_o=0 and stall_o=1.
    - bus_rvalid_i=1 -> DONE; capture read_data_o and set bus_err_o from bus_err_i.
  - DONE:
    - done_o=1 and stall_o=0 for exactly one cycle, then -> IDLE.
    - read_data_o, misaligned_o and bus_err_o hold their values during DONE and are cleared to 0 on leaving.
- Timeout:
  - The counter clears on entry to ADDR and increments every cycle spent in ADDR or RESP.
  - When count reaches TIMEOUT_CYCLES-1 without completion, the next cycle is DONE with bus_err_o=1 and read_data_o=0.
  - Leaving ADDR by timeout also drops bus_valid_o.
- Ignored events:
  - bus_rvalid_i is ignored in IDLE, ADDR and DONE.
  - bus_ready_i is ignored outside ADDR.
  - mem_req_i seen in DONE is not accepted; the request is re-sampled in IDLE on the next cycle.
- Latency: a zero-wait bus (ready in the first ADDR cycle, rvalid in the first RESP cycle) gives request cycle 0 (IDLE), 1 (ADDR), 2 (RESP), with done_o=1 in cycle 3.
- Simultaneous rvalid and timeout in the same cycle: rvalid wins; data is captured and bus_err_o = bus_err_i.

Test Plan:
1. Word load, addr=0x100, zero-wait bus, rdata=0xDEADBEEF -> bus_addr_o=0x100, bus_wstrb_o=0000; done_o in cycle 3 with read_data_o=0xDEADBEEF; stall_o high in cycles 0-2.
2. Byte store, addr=0x203, data=0x000000A5, strobe=0001 -> bus_addr_o=0x200, bus_wdata_o=0xA5000000, bus_wstrb_o=1000, bus_we_o=1.
3. Half load, addr=0x105 -> no bus_valid_o; done_o in the cycle after the request with misaligned_o=1. Half load, addr=0x106, rdata=0x8001ABCD -> read_data_o=0x00008001.
4. bus_ready_i held low 3 cycles in ADDR -> bus_valid_o and bus_addr_o stable for 4 cycles; done_o in cycle 6.
5. TIMEOUT_CYCLES=8, bus_rvalid_i never asserted -> done_o with bus_err_o=1 and read_data_o=0 in cycle 9.
6. rst_ni pulsed low during RESP -> outputs 0 immediately, state IDLE. A late bus_rvalid_i after reset is ignored, and the next request completes normally.
